// File: rtl/dram_bus_ctrl_if.sv
// Core-side request/completion handshake of the memory bus initiator.
// The core is the master; dram_bus_ctrl is the slave.
interface dram_bus_ctrl_if;
  logic        core_req;
  logic        core_wr;
  logic [14:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_be;
  logic        core_ready;
  logic        core_done;
  logic [31:0] core_rdata;

  modport master (
    output core_req, core_wr, core_addr, core_wdata, core_be,
    input  core_ready, core_done, core_rdata
  );

  modport slave (
    input  core_req, core_wr, core_addr, core_wdata, core_be,
    output core_ready, core_done, core_rdata
  );
endinterface

// File: rtl/dram_bus_ctrl.sv
// Single-access bus initiator for the 32 KB byte-enabled SRAM array.
// Sequences address/data/OE and the active-low write strobe; times phases with a down-counter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ready for a request, bus released (OE=0, strobe high)
// S_WSETUP | write: address/data/we driven, strobe high, SETUP_CYC cycles
// S_WPULSE | write: strobe low for PULSE_CYC cycles
// S_WHOLD  | write: strobe high, bus still driven for one hold cycle
// S_RWAIT  | read: address driven, memory drives DataIO, READ_CYC cycles
// S_DONE   | one-cycle completion pulse to the core
module dram_bus_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned READ_CYC  = 3
) (
  input  logic             CLK,
  input  logic             CLR,
  dram_bus_ctrl_if.slave   core,
  output logic [14:0]      Address,
  inout  wire  [31:0]      DataIO,
  output logic [3:0]       we,
  output logic             OE,
  output logic             write_signal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WSETUP,
    S_WPULSE,
    S_WHOLD,
    S_RWAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] LP_PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] LP_READ_LD  = 4'(READ_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_tc;
  logic        w_accept;
  logic        w_capture;
  logic        w_oe_nxt;
  logic        w_ws_nxt;

  logic [14:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_oe;
  logic        r_ws;

  assign w_tc = (r_cnt == 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (core.core_req) begin
          w_accept = 1'b1;
          if (core.core_wr) begin
            w_state_nxt = S_WSETUP;
            w_cnt_nxt   = LP_SETUP_LD;
          end else begin
            w_state_nxt = S_RWAIT;
            w_cnt_nxt   = LP_READ_LD;
          end
        end
      end
      S_WSETUP: begin
        if (w_tc) begin
          w_state_nxt = S_WPULSE;
          w_cnt_nxt   = LP_PULSE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_WPULSE: begin
        if (w_tc) begin
          w_state_nxt = S_WHOLD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_WHOLD: begin
        w_state_nxt = S_DONE;
      end
      S_RWAIT: begin
        if (w_tc) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // OE and strobe are decoded from the next state and registered, so the pins never glitch
    w_oe_nxt = (w_state_nxt == S_WSETUP) || (w_state_nxt == S_WPULSE) ||
               (w_state_nxt == S_WHOLD);
    w_ws_nxt = (w_state_nxt != S_WPULSE);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_oe    <= 1'b0;
      r_ws    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_oe    <= w_oe_nxt;
      r_ws    <= w_ws_nxt;
    end
  end

  // Request fields are latched once at acceptance and held for the whole access
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_addr  <= 15'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
    end else if (w_accept) begin
      r_addr  <= core.core_addr;
      r_wdata <= core.core_wdata;
      r_be    <= core.core_be;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_rdata <= 32'd0;
    end else if (w_capture) begin
      r_rdata <= DataIO;
    end
  end

  assign DataIO       = r_oe ? r_wdata : 32'bz;
  assign Address      = r_addr;
  assign we           = r_be;
  assign OE           = r_oe;
  assign write_signal = r_ws;

  assign core.core_ready = (r_state == S_IDLE);
  assign core.core_done  = (r_state == S_DONE);
  assign core.core_rdata = r_rdata;

endmodule

// File: doc/dram_bus_ctrl.md
# dram_bus_ctrl

Bus initiator for the 32 KB byte-enabled SRAM-array memory. It accepts single read/write requests from the core side through a ready/done handshake. It then drives the memory's 15-bit address, 32-bit bidirectional data bus, byte enables, OE direction line and active-low write strobe. Write strobe width and read access time are set by parameters. It sits between the core's load/store path and the memory array, and is the only driver of the memory bus.

## Interface
- SETUP_CYC, 1: cycles address/data/we/OE are stable before the write strobe falls (1..15).
- PULSE_CYC, 2: cycles write_signal is held low (1..15).
- READ_CYC, 3: cycles from read launch to DataIO capture (1..15).

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- CLR  in  1  asynchronous, active-low reset.
- core_req  in  1  request valid; sampled only while core_ready=1.
- core_wr  in  1  1=write, 0=read.
- core_addr  in  15  byte address; [14:2] selects the word, [1:0] ignored.
- core_wdata  in  32  write data, lane layout [31:24]..[7:0].
- core_be  in  4  byte enables, forwarded unchanged to we.
- core_ready  out  1  controller idle; accepts a request this cycle.
- core_done  out  1  one-cycle completion pulse.
- core_rdata  out  32  read data; valid while core_done=1, held until the next read capture.
- Address  out  15  memory address.
- DataIO  inout  32  memory data bus; driven by this block only while OE=1.
- we  out  4  memory byte write enables.
- OE  out  1  1=write direction (controller drives DataIO), 0=read (memory drives).
- write_signal  out  1  active-low write strobe; memory writes only while write_signal=0 and OE=1.

## Operation
- States: IDLE, WSETUP, WPULSE, WHOLD, RWAIT, DONE. A 4-bit down-counter times WSETUP, WPULSE and RWAIT.
- IDLE: core_ready=1, OE=0, write_signal=1, DataIO released. On core_req=1, latch addr/wdata/be/wr.
  - wr=1: go to WSETUP, counter=SETUP_CYC-1.
  - wr=0: go to RWAIT, counter=READ_CYC-1.
- WSETUP: OE=1, Address, we and DataIO driven from latches, write_signal=1. When counter hits 0, go to WPULSE with counter=PULSE_CYC-1.
- WPULSE: write_signal=0, all else unchanged. When counter hits 0, go to WHOLD.
- WHOLD: write_signal=1, OE/Address/DataIO/we still held for one cycle to meet memory hold time. Then go to DONE.
- RWAIT: OE=0, Address driven, we=latched be, DataIO released. When counter hits 0, register DataIO into core_rdata and go to DONE.
- DONE: core_done=1, OE=0, write_signal=1. Go to IDLE next cycle.
- core_req outside IDLE is ignored; the core holds the request until core_ready.
- Invariants:
  - OE never changes in a cycle where write_signal=0.
  - write_signal and OE are registered outputs (glitch-free).
  - DataIO is tri-stated whenever OE=0.
  - A write with core_be=0000 still runs the full sequence.
- Reset values (CLR=0, immediate):
  - state=IDLE, core_ready=1, core_done=0, core_rdata=0.
  - Address=0, we=0, OE=0, write_signal=1, DataIO released.
- Reset mid-write truncates the strobe at once. The memory word contents are then undefined for that access only.

## Timing
- Request accepted at edge E (end of cycle n).
- Write:
  - WSETUP in cycles n+1..n+SETUP_CYC.
  - write_signal low for exactly PULSE_CYC cycles.
  - WHOLD 1 cycle, then core_done in cycle n+SETUP_CYC+PULSE_CYC+2 (defaults: n+5).
- Read:
  - DataIO sampled at the end of cycle n+READ_CYC.
  - core_done and core_rdata valid in cycle n+READ_CYC+1 (defaults: n+4).
- core_ready returns the cycle after DONE. Back-to-back throughput with defaults: one write per 6 cycles, one read per 5 cycles.
- Address/we/DataIO change only on edges where write_signal is high.

## Test plan
- Reset: CLR low mid-cycle -> outputs immediately take reset values (OE=0, write_signal=1, core_ready=1), DataIO=Z.
- Write: write addr 0x1234, wdata 0xDEADBEEF, be=1111, then read the same address -> write_signal low exactly cycles n+2..n+3, core_done at n+5; read core_rdata=0xDEADBEEF at n+4.
- Partial write: be=0100 with wdata 0x00AA0000 over a word holding 0x11223344 -> readback 0x11AA3344.
- Bank coverage: write distinct patterns to 0x0000, 0x2000, 0x4000, 0x6000, read all four -> each returns its own pattern (no aliasing across Address[14:13]).
- Busy handling: core_req pulsed during WPULSE with different addr -> ignored, and memory is unchanged at that address. A held request is accepted on the first core_ready cycle.
- Reset mid-write: CLR asserted during WPULSE -> write_signal=1 in the same cycle. Next request after release completes normally. Sweep parameters (1,1,1) and (3,4,7) and check the latency formulas.
